butterfly_pipe: RTL and testbench
=================================

BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 Parameter: DATA_W, 16, signed width of each real/imag sample (Q1.15).
REQ-002 Parameter: SCALE, 1, 1 = halve butterfly outputs by arithmetic shift right; 0 = no shift, saturate.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 clr  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair valid this cycle (memory-read-aligned mem_write).
REQ-006 a_re, a_im, b_re, b_im  in  DATA_W each  butterfly operands a, b.
REQ-007 twiddle_address  in  4  twiddle index k, 0..15.
REQ-008 mema_address, memb_address  in  5 each  source addresses of a and b.
REQ-009 bank_select_in  in  1  read bank of this operand pair.
REQ-010 out_valid  out  1  results valid this cycle.
REQ-011 A_re, A_im, B_re, B_im  out  DATA_W each  butterfly results.
REQ-012 wr_addr_a, wr_addr_b  out  5 each  write-back addresses for A and B.
REQ-013 bank_select_out  out  1  bank tag aligned with results.
REQ-014 busy  out  1  high while any pipeline stage holds a valid entry.

Function
REQ-015 Compute A = a + W*b and B = a - W*b, where W = W_k = exp(-j*2*pi*k/32).
REQ-016 Twiddle ROM: re = round(32767*cos(2*pi*k/32)); im = -round(32767*sin(2*pi*k/32)); k=0 gives (0x7FFF, 0).
REQ-017 Pipeline has 4 stages:
- S1 registers operands and performs the ROM lookup.
- S2 registers the four 32-bit products.
- S3 forms the sums, rounds and saturates.
- S4 adds/subtracts and scales.
REQ-018 Latency is exactly 4 cycles from in_valid to out_valid; throughput is one pair per cycle; there is no backpressure.
REQ-019 Product rounding: each real/imag sum is formed at 33 bits, 2^14 is added, the result is arithmetically shifted right by 15, then saturated to [-32768, 32767].
REQ-020 S4 arithmetic:
- A and B are formed at DATA_W+1 bits.
- SCALE=1: arithmetic shift right by 1 (floor); this cannot overflow.
- SCALE=0: saturate to DATA_W.
REQ-021 wr_addr_a, wr_addr_b and bank_select_out shall be delayed 4 cycles with their operands; they equal the mema_address, memb_address and bank_select_in captured with the same in_valid.
REQ-022 Data, address and bank registers load only when the corresponding stage valid is high; otherwise they hold their previous values.
REQ-023 When out_valid=0, outputs retain their last values; consumers ignore them.
REQ-024 in_valid gaps propagate as bubbles; no reordering and no merging of entries.
REQ-025 busy = OR of the four stage-valid bits; it falls 4 cycles after the last in_valid.

Reset
REQ-026 While clr=1 on a clock edge, the following clear to 0: all stage valids, out_valid, busy, every data output, wr_addr_a/b and bank_select_out.
REQ-027 A clr asserted mid-stream discards all in-flight entries; no out_valid is produced for them.
REQ-028 An in_valid sampled in the same cycle as clr=1 is dropped.
REQ-029 The first accepted entry after clr deasserts appears exactly 4 cycles later.

Structure
REQ-030 A shared fft_pkg holds FFT_N=32, DATA_W=16, ADDR_W=5 and TW_ADDR_W=4; it is reused by the address generator and the memory banks.
REQ-031 The twiddle table is a separate sub-module, twiddle_rom: a 4-bit address in, a 16+16-bit W out, registered and used in S1.
REQ-032 The complex multiply stays inline; no other sub-modules.

Verification
REQ-033 Identity twiddle: k=0, a=(0x4000,0), b=(0x2000,0), SCALE=1 -> 4 cycles later A=(0x3000,0), B=(0x1000,0).
REQ-034 -j twiddle: k=8, a=(0x4000,0), b=(0x2000,0), SCALE=1 -> A=(0x2000,0xF000), B=(0x2000,0x1000).
REQ-035 Product saturation: k=4, a=(0,0), b=(0x7FFF,0x7FFF), SCALE=1 -> W*b.re saturates to 0x7FFF; A=(0x3FFF,0), B=(0xC000,0).
REQ-036 Streaming: 16 back-to-back pairs with ramping addresses, then a 3-cycle gap, then 4 more pairs -> 20 out_valid pulses with the same gap; wr_addr_a/b and bank_select_out match their inputs; busy drops 4 cycles after the last input.
REQ-037 Reset mid-stream: clr pulsed for 1 cycle while 3 entries are in flight -> no out_valid for them; all outputs are 0; the next input emerges exactly 4 cycles later.
REQ-038 Random vectors: 1000 random operand pairs with random k, SCALE=0 and SCALE=1 -> outputs bit-exact against a reference model implementing REQ-016, REQ-019 and REQ-020.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants and fixed-point helpers for the butterfly, address generator and banks.
package fft_pkg;

    localparam int unsigned FFT_N     = 32;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned TW_ADDR_W = 4;

    localparam logic signed [2*DATA_W:0] RND_BIAS = (2*DATA_W+1)'(2**(DATA_W-2));
    localparam logic signed [2*DATA_W:0] WIDE_MAX = (2*DATA_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [2*DATA_W:0] WIDE_MIN = (2*DATA_W+1)'(-(2**(DATA_W-1)));
    localparam logic signed [DATA_W:0]   NARROW_MAX = (DATA_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [DATA_W:0]   NARROW_MIN = (DATA_W+1)'(-(2**(DATA_W-1)));
    localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Q2.30 product sum -> Q1.15: round half up, then clamp.
    function automatic logic signed [DATA_W-1:0] round_sat_prod(
        input logic signed [2*DATA_W:0] s
    );
        logic signed [2*DATA_W:0] t;
        t = (s + RND_BIAS) >>> (DATA_W-1);
        if (t > WIDE_MAX) begin
            return D_MAX;
        end else if (t < WIDE_MIN) begin
            return D_MIN;
        end
        return t[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_narrow(input logic signed [DATA_W:0] s);
        if (s > NARROW_MAX) begin
            return D_MAX;
        end else if (s < NARROW_MIN) begin
            return D_MIN;
        end
        return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Registered twiddle table W_k = exp(-j*2*pi*k/32) for k = 0..15, Q1.15 scaled by 32767.
module twiddle_rom
    import fft_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_en,
    input  logic [TW_ADDR_W-1:0]        i_addr,
    output logic signed [DATA_W-1:0]    o_w_re,
    output logic signed [DATA_W-1:0]    o_w_im
);

    logic signed [DATA_W-1:0] w_cos;
    logic signed [DATA_W-1:0] w_sin;
    logic signed [DATA_W-1:0] r_re;
    logic signed [DATA_W-1:0] r_im;

    always_comb begin
        w_cos = '0;
        w_sin = '0;
        unique case (i_addr)
            4'd0:  begin w_cos =  16'sd32767; w_sin = 16'sd0;     end
            4'd1:  begin w_cos =  16'sd32137; w_sin = 16'sd6393;  end
            4'd2:  begin w_cos =  16'sd30273; w_sin = 16'sd12539; end
            4'd3:  begin w_cos =  16'sd27245; w_sin = 16'sd18204; end
            4'd4:  begin w_cos =  16'sd23170; w_sin = 16'sd23170; end
            4'd5:  begin w_cos =  16'sd18204; w_sin = 16'sd27245; end
            4'd6:  begin w_cos =  16'sd12539; w_sin = 16'sd30273; end
            4'd7:  begin w_cos =  16'sd6393;  w_sin = 16'sd32137; end
            4'd8:  begin w_cos =  16'sd0;     w_sin = 16'sd32767; end
            4'd9:  begin w_cos = -16'sd6393;  w_sin = 16'sd32137; end
            4'd10: begin w_cos = -16'sd12539; w_sin = 16'sd30273; end
            4'd11: begin w_cos = -16'sd18204; w_sin = 16'sd27245; end
            4'd12: begin w_cos = -16'sd23170; w_sin = 16'sd23170; end
            4'd13: begin w_cos = -16'sd27245; w_sin = 16'sd18204; end
            4'd14: begin w_cos = -16'sd30273; w_sin = 16'sd12539; end
            4'd15: begin w_cos = -16'sd32137; w_sin = 16'sd6393;  end
        endcase
    end

    // Imaginary part is -sin for the forward transform.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_re <= w_cos;
            r_im <= -w_sin;
        end
    end

    assign o_w_re = r_re;
    assign o_w_im = r_im;

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage radix-2 DIT butterfly: A = a + W*b, B = a - W*b, with write-back address tagging.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SCALE  = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic [TW_ADDR_W-1:0]     twiddle_address,
    input  logic [ADDR_W-1:0]        mema_address,
    input  logic [ADDR_W-1:0]        memb_address,
    input  logic                     bank_select_in,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] A_re,
    output logic signed [DATA_W-1:0] A_im,
    output logic signed [DATA_W-1:0] B_re,
    output logic signed [DATA_W-1:0] B_im,
    output logic [ADDR_W-1:0]        wr_addr_a,
    output logic [ADDR_W-1:0]        wr_addr_b,
    output logic                     bank_select_out,
    output logic                     busy
);

    localparam int PW = 2 * DATA_W;

    logic r_v1, r_v2, r_v3, r_v4;

    logic signed [DATA_W-1:0] r1_a_re, r1_a_im, r1_b_re, r1_b_im;
    logic signed [DATA_W-1:0] w_tw_re, w_tw_im;
    logic [ADDR_W-1:0]        r1_addr_a, r1_addr_b, r2_addr_a, r2_addr_b, r3_addr_a, r3_addr_b;
    logic                     r1_bank, r2_bank, r3_bank;

    logic signed [DATA_W-1:0] r2_a_re, r2_a_im;
    logic signed [PW-1:0]     r2_p_rr, r2_p_ii, r2_p_ri, r2_p_ir;

    logic signed [PW:0]       w_sum_re, w_sum_im;
    logic signed [DATA_W-1:0] r3_a_re, r3_a_im, r3_wb_re, r3_wb_im;

    logic signed [DATA_W:0]   w_add_re, w_add_im, w_sub_re, w_sub_im;
    logic signed [DATA_W-1:0] w_A_re, w_A_im, w_B_re, w_B_im;

    logic signed [DATA_W-1:0] r_A_re, r_A_im, r_B_re, r_B_im;
    logic [ADDR_W-1:0]        r_wr_addr_a, r_wr_addr_b;
    logic                     r_bank_out;

    twiddle_rom u_twiddle_rom (
        .i_clk  (clk),
        .i_en   (in_valid),
        .i_addr (twiddle_address),
        .o_w_re (w_tw_re),
        .o_w_im (w_tw_im)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
        end
    end

    // Internal pipeline data is only ever consumed behind its valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r1_a_re   <= a_re;
            r1_a_im   <= a_im;
            r1_b_re   <= b_re;
            r1_b_im   <= b_im;
            r1_addr_a <= mema_address;
            r1_addr_b <= memb_address;
            r1_bank   <= bank_select_in;
        end
        if (r_v1) begin
            r2_a_re   <= r1_a_re;
            r2_a_im   <= r1_a_im;
            r2_p_rr   <= PW'(r1_b_re) * PW'(w_tw_re);
            r2_p_ii   <= PW'(r1_b_im) * PW'(w_tw_im);
            r2_p_ri   <= PW'(r1_b_re) * PW'(w_tw_im);
            r2_p_ir   <= PW'(r1_b_im) * PW'(w_tw_re);
            r2_addr_a <= r1_addr_a;
            r2_addr_b <= r1_addr_b;
            r2_bank   <= r1_bank;
        end
        if (r_v2) begin
            r3_a_re   <= r2_a_re;
            r3_a_im   <= r2_a_im;
            r3_wb_re  <= round_sat_prod(w_sum_re);
            r3_wb_im  <= round_sat_prod(w_sum_im);
            r3_addr_a <= r2_addr_a;
            r3_addr_b <= r2_addr_b;
            r3_bank   <= r2_bank;
        end
    end

    always_comb begin
        w_sum_re = (PW+1)'(r2_p_rr) - (PW+1)'(r2_p_ii);
        w_sum_im = (PW+1)'(r2_p_ri) + (PW+1)'(r2_p_ir);
    end

    always_comb begin
        w_add_re = (DATA_W+1)'(r3_a_re) + (DATA_W+1)'(r3_wb_re);
        w_add_im = (DATA_W+1)'(r3_a_im) + (DATA_W+1)'(r3_wb_im);
        w_sub_re = (DATA_W+1)'(r3_a_re) - (DATA_W+1)'(r3_wb_re);
        w_sub_im = (DATA_W+1)'(r3_a_im) - (DATA_W+1)'(r3_wb_im);
        if (SCALE != 0) begin
            w_A_re = DATA_W'(w_add_re >>> 1);
            w_A_im = DATA_W'(w_add_im >>> 1);
            w_B_re = DATA_W'(w_sub_re >>> 1);
            w_B_im = DATA_W'(w_sub_im >>> 1);
        end else begin
            w_A_re = sat_narrow(w_add_re);
            w_A_im = sat_narrow(w_add_im);
            w_B_re = sat_narrow(w_sub_re);
            w_B_im = sat_narrow(w_sub_im);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_A_re      <= '0;
            r_A_im      <= '0;
            r_B_re      <= '0;
            r_B_im      <= '0;
            r_wr_addr_a <= '0;
            r_wr_addr_b <= '0;
            r_bank_out  <= 1'b0;
        end else if (r_v3) begin
            r_A_re      <= w_A_re;
            r_A_im      <= w_A_im;
            r_B_re      <= w_B_re;
            r_B_im      <= w_B_im;
            r_wr_addr_a <= r3_addr_a;
            r_wr_addr_b <= r3_addr_b;
            r_bank_out  <= r3_bank;
        end
    end

    assign out_valid       = r_v4;
    assign busy            = r_v1 | r_v2 | r_v3 | r_v4;
    assign A_re            = r_A_re;
    assign A_im            = r_A_im;
    assign B_re            = r_B_re;
    assign B_im            = r_B_im;
    assign wr_addr_a       = r_wr_addr_a;
    assign wr_addr_b       = r_wr_addr_b;
    assign bank_select_out = r_bank_out;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Bench for butterfly_pipe: scaled and saturating instances share stimulus, checked against
// a real-arithmetic butterfly model with a timestamped expectation queue.
module tb_butterfly_pipe;

    typedef struct {
        int          due;
        logic [63:0] o1;
        logic [63:0] o0;
        logic [10:0] ad;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic [15:0] a_re, a_im, b_re, b_im;
    logic [3:0]  tw;
    logic [4:0]  mema, memb;
    logic        bank_in;

    logic        s1_v, s1_busy, s1_bank;
    logic [15:0] s1_are, s1_aim, s1_bre, s1_bim;
    logic [4:0]  s1_wa, s1_wb;
    logic        s0_v, s0_busy, s0_bank;
    logic [15:0] s0_are, s0_aim, s0_bre, s0_bim;
    logic [4:0]  s0_wa, s0_wb;

    exp_t        q[$];
    logic [63:0] hold1, hold0;
    logic [10:0] hold_ad;
    int          pcnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          nvalid = 0;

    always #5 clk = ~clk;

    butterfly_pipe #(.DATA_W(16), .SCALE(1)) u_dut_s1 (
        .clk(clk), .clr(clr), .in_valid(in_valid),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .twiddle_address(tw), .mema_address(mema), .memb_address(memb),
        .bank_select_in(bank_in), .out_valid(s1_v),
        .A_re(s1_are), .A_im(s1_aim), .B_re(s1_bre), .B_im(s1_bim),
        .wr_addr_a(s1_wa), .wr_addr_b(s1_wb), .bank_select_out(s1_bank), .busy(s1_busy)
    );

    butterfly_pipe #(.DATA_W(16), .SCALE(0)) u_dut_s0 (
        .clk(clk), .clr(clr), .in_valid(in_valid),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .twiddle_address(tw), .mema_address(mema), .memb_address(memb),
        .bank_select_in(bank_in), .out_valid(s0_v),
        .A_re(s0_are), .A_im(s0_aim), .B_re(s0_bre), .B_im(s0_bim),
        .wr_addr_a(s0_wa), .wr_addr_b(s0_wb), .bank_select_out(s0_bank), .busy(s0_busy)
    );

    function automatic int rnd(real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int sat16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic logic [63:0] bfly(int ar, int ai, int br, int bi, int k, bit scale1);
        real    ang;
        int     wr, wi, tr, ti, xa_r, xa_i, xb_r, xb_i;
        longint pr, pi;
        ang  = 2.0 * 3.14159265358979 * k / 32.0;
        wr   = rnd(32767.0 * $cos(ang));
        wi   = -rnd(32767.0 * $sin(ang));
        pr   = longint'(wr) * br - longint'(wi) * bi;
        pi   = longint'(wr) * bi + longint'(wi) * br;
        tr   = sat16((pr + 16384) >>> 15);
        ti   = sat16((pi + 16384) >>> 15);
        xa_r = ar + tr;
        xa_i = ai + ti;
        xb_r = ar - tr;
        xb_i = ai - ti;
        if (scale1) begin
            xa_r = xa_r >>> 1; xa_i = xa_i >>> 1; xb_r = xb_r >>> 1; xb_i = xb_i >>> 1;
        end else begin
            xa_r = sat16(xa_r); xa_i = sat16(xa_i); xb_r = sat16(xb_r); xb_i = sat16(xb_i);
        end
        return {16'(xa_r), 16'(xa_i), 16'(xb_r), 16'(xb_i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model the sampled inputs at the edge, then compare every output mid-cycle.
    task automatic step();
        exp_t e;
        logic exp_v;
        logic exp_busy;
        @(posedge clk);
        pcnt++;
        if (clr) begin
            q.delete();
            hold1   = '0;
            hold0   = '0;
            hold_ad = '0;
        end else if (in_valid) begin
            e.due = pcnt + 3;
            e.o1  = bfly(int'($signed(a_re)), int'($signed(a_im)), int'($signed(b_re)),
                         int'($signed(b_im)), int'(tw), 1'b1);
            e.o0  = bfly(int'($signed(a_re)), int'($signed(a_im)), int'($signed(b_re)),
                         int'($signed(b_im)), int'(tw), 1'b0);
            e.ad  = {mema, memb, bank_in};
            q.push_back(e);
        end
        @(negedge clk);
        exp_busy = (q.size() != 0);
        exp_v    = (q.size() != 0) && (q[0].due == pcnt);
        if (exp_v) begin
            hold1   = q[0].o1;
            hold0   = q[0].o0;
            hold_ad = q[0].ad;
            void'(q.pop_front());
        end
        if (s1_v) nvalid++;
        chk("s1 valid", 64'(s1_v), 64'(exp_v));
        chk("s0 valid", 64'(s0_v), 64'(exp_v));
        chk("s1 busy", 64'(s1_busy), 64'(exp_busy));
        chk("s0 busy", 64'(s0_busy), 64'(exp_busy));
        chk("s1 data", {s1_are, s1_aim, s1_bre, s1_bim}, hold1);
        chk("s0 data", {s0_are, s0_aim, s0_bre, s0_bim}, hold0);
        chk("s1 addr", 64'({s1_wa, s1_wb, s1_bank}), 64'(hold_ad));
        chk("s0 addr", 64'({s0_wa, s0_wb, s0_bank}), 64'(hold_ad));
    endtask

    task automatic drive(input logic [15:0] ar, ai, br, bi, input logic [3:0] k,
                         input logic [4:0] ma, mb, input logic bk);
        in_valid = 1'b1;
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        tw = k; mema = ma; memb = mb; bank_in = bk;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int sent;
        clr = 1'b1; in_valid = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        tw = '0; mema = '0; memb = '0; bank_in = 1'b0;
        step();
        step();
        clr = 1'b0;
        idle(1);

        // Identity twiddle
        drive(16'h4000, 16'h0000, 16'h2000, 16'h0000, 4'd0, 5'd3, 5'd19, 1'b1);
        idle(3);
        chk("k0 scaled", {s1_are, s1_aim, s1_bre, s1_bim}, 64'h3000_0000_1000_0000);
        chk("k0 sat", {s0_are, s0_aim, s0_bre, s0_bim}, 64'h6000_0000_2000_0000);
        chk("k0 addr", 64'({s1_wa, s1_wb, s1_bank}), 64'({5'd3, 5'd19, 1'b1}));
        idle(2);

        // -j twiddle
        drive(16'h4000, 16'h0000, 16'h2000, 16'h0000, 4'd8, 5'd7, 5'd23, 1'b0);
        idle(3);
        chk("k8 scaled", {s1_are, s1_aim, s1_bre, s1_bim}, 64'h2000_F000_2000_1000);
        chk("k8 sat", {s0_are, s0_aim, s0_bre, s0_bim}, 64'h4000_E000_4000_2000);
        idle(2);

        // Product saturation
        drive(16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 4'd4, 5'd1, 5'd2, 1'b1);
        idle(3);
        chk("k4 scaled", {s1_are, s1_aim, s1_bre, s1_bim}, 64'h3FFF_0000_C000_0000);
        chk("k4 sat", {s0_are, s0_aim, s0_bre, s0_bim}, 64'h7FFF_0000_8001_0000);
        idle(2);

        // Streaming with a 3-cycle gap
        nvalid = 0;
        for (int i = 0; i < 16; i++)
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'(i),
                  5'(i), 5'(i + 16), i[0]);
        idle(3);
        for (int i = 0; i < 4; i++)
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'(i + 3),
                  5'(i + 8), 5'(i + 24), i[1]);
        idle(3);
        chk("busy last", 64'(s1_busy), 64'd1);
        idle(1);
        chk("busy drop", 64'(s1_busy), 64'd0);
        idle(2);
        chk("stream pulses", 64'(nvalid), 64'd20);

        // Reset mid-stream, with an in_valid coinciding with clr
        for (int i = 0; i < 3; i++)
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'(i),
                  5'(i), 5'(i), 1'b1);
        clr = 1'b1;
        drive(16'h1234, 16'h1234, 16'h1234, 16'h1234, 4'd1, 5'd9, 5'd9, 1'b1);
        clr = 1'b0;
        chk("clr data", {s1_are, s1_aim, s1_bre, s1_bim}, 64'd0);
        chk("clr busy", 64'(s0_busy), 64'd0);
        idle(4);
        drive(16'h0100, 16'h0200, 16'h0300, 16'h0400, 4'd2, 5'd5, 5'd6, 1'b1);
        idle(3);
        chk("post clr valid", 64'(s1_v), 64'd1);
        idle(2);

        // Random operands with random gaps
        sent = 0;
        while (sent < 1000) begin
            if ($urandom_range(0, 4) != 0) begin
                drive(pick(), pick(), pick(), pick(), 4'($urandom_range(0, 15)),
                      5'($urandom), 5'($urandom), 1'($urandom));
                sent++;
            end else begin
                idle(1);
            end
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
